// File: rtl/lc3_pkg.sv
// Shared LC-3 sequencer definitions: opcodes, ALU control encodings,
// FSM state encoding and the condition-code reset value.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_NOT  = 2'd3;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StHalt   = 2'd3
    } state_e;

    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Combinational condition-code generator.
// Ports:
//   value : 16-bit result to classify
//   nzp   : one-hot {N,Z,P}
module lc3_nzp_gen (
    input  logic [15:0] value,
    output logic [2:0]  nzp
);

    always_comb begin
        if (value[15]) begin
            nzp = 3'b100;
        end else if (value == 16'h0000) begin
            nzp = 3'b010;
        end else begin
            nzp = 3'b001;
        end
    end

endmodule

// File: rtl/lc3_alu_sequencer.sv
// LC-3 fetch/decode/execute sequencer driving an external ALU and register file.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_req/mem_addr    : instruction fetch request and address (ready/valid)
//   mem_rdata/mem_ready : fetched instruction word and accept strobe
//   alu_ctrl/alu_ir     : ALU operation select and IR[5:0] (imm5 + select)
//   sr1/sr2/dr          : register-file read A, read B and write addresses
//   reg_we              : one-cycle register-file write enable
//   alu_result          : ALU output for the current selects
//   pc/nzp/halted       : program counter, condition codes, halt status
module lc3_alu_sequencer
    import lc3_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h3000,
    parameter logic [7:0]  HALT_VECTOR = 8'h25
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  alu_ctrl,
    output logic [5:0]  alu_ir,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [2:0]  dr,
    output logic        reg_we,
    input  logic [15:0] alu_result,
    output logic [15:0] pc,
    output logic [2:0]  nzp,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [1:0]  alu_ctrl_q, alu_ctrl_d;
    logic [5:0]  alu_ir_q, alu_ir_d;
    logic [2:0]  sr1_q, sr1_d;
    logic [2:0]  sr2_q, sr2_d;
    logic [2:0]  dr_q, dr_d;
    logic        reg_we_q, reg_we_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        halted_q, halted_d;

    logic [2:0]  result_nzp;
    logic [15:0] br_offset;

    lc3_nzp_gen u_nzp_gen (
        .value (alu_result),
        .nzp   (result_nzp)
    );

    assign br_offset = {{7{ir_q[8]}}, ir_q[8:0]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_req_d  = mem_req_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_ir_d   = alu_ir_q;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        dr_d       = dr_q;
        reg_we_d   = 1'b0;
        nzp_d      = nzp_q;
        halted_d   = halted_q;

        unique case (state_q)
            StFetch: begin
                // mem_req is only low here straight after reset; raise it first.
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (mem_ready) begin
                    ir_d      = mem_rdata;
                    pc_d      = pc_q + 16'd1;
                    mem_req_d = 1'b0;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                sr1_d    = ir_q[8:6];
                sr2_d    = ir_q[2:0];
                dr_d     = ir_q[11:9];
                alu_ir_d = ir_q[5:0];
                // Leaving for FETCH raises mem_req now so the next fetch is not delayed.
                state_d   = StFetch;
                mem_req_d = 1'b1;
                case (ir_q[15:12])
                    OP_ADD, OP_AND, OP_NOT: begin
                        if (ir_q[15:12] == OP_ADD) begin
                            alu_ctrl_d = ALU_ADD;
                        end else if (ir_q[15:12] == OP_AND) begin
                            alu_ctrl_d = ALU_AND;
                        end else begin
                            alu_ctrl_d = ALU_NOT;
                        end
                        reg_we_d  = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = StExec;
                    end
                    OP_BR: begin
                        if ((ir_q[11:9] & nzp_q) != 3'b000) begin
                            pc_d = pc_q + br_offset;
                        end
                    end
                    OP_TRAP: begin
                        if (ir_q[7:0] == HALT_VECTOR) begin
                            halted_d  = 1'b1;
                            mem_req_d = 1'b0;
                            state_d   = StHalt;
                        end
                    end
                    default: ;
                endcase
            end
            StExec: begin
                nzp_d     = result_nzp;
                mem_req_d = 1'b1;
                state_d   = StFetch;
            end
            StHalt: begin
                halted_d  = 1'b1;
                mem_req_d = 1'b0;
            end
            default: state_d = StFetch;
        endcase

        // Address tracks pc so it is stable for the whole time mem_req is high.
        mem_addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= PC_RESET;
            ir_q       <= 16'h0000;
            mem_req_q  <= 1'b0;
            mem_addr_q <= PC_RESET;
            alu_ctrl_q <= ALU_PASS;
            alu_ir_q   <= 6'h00;
            sr1_q      <= 3'd0;
            sr2_q      <= 3'd0;
            dr_q       <= 3'd0;
            reg_we_q   <= 1'b0;
            nzp_q      <= NZP_RESET;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_ir_q   <= alu_ir_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            dr_q       <= dr_d;
            reg_we_q   <= reg_we_d;
            nzp_q      <= nzp_d;
            halted_q   <= halted_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign alu_ctrl = alu_ctrl_q;
    assign alu_ir   = alu_ir_q;
    assign sr1      = sr1_q;
    assign sr2      = sr2_q;
    assign dr       = dr_q;
    assign reg_we   = reg_we_q;
    assign pc       = pc_q;
    assign nzp      = nzp_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Directed self-checking bench for lc3_alu_sequencer. A second instance with
// PC_RESET=16'hFFFF exercises the pc wrap-around.
module tb_lc3_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_w = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] alu_result = 16'h0000;

    logic        mem_req, reg_we, halted;
    logic [15:0] mem_addr, pc;
    logic [1:0]  alu_ctrl;
    logic [5:0]  alu_ir;
    logic [2:0]  sr1, sr2, dr, nzp;

    logic        w_mem_req, w_reg_we, w_halted;
    logic [15:0] w_mem_addr, w_pc;
    logic [1:0]  w_alu_ctrl;
    logic [5:0]  w_alu_ir;
    logic [2:0]  w_sr1, w_sr2, w_dr, w_nzp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_alu_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_ir     (alu_ir),
        .sr1        (sr1),
        .sr2        (sr2),
        .dr         (dr),
        .reg_we     (reg_we),
        .alu_result (alu_result),
        .pc         (pc),
        .nzp        (nzp),
        .halted     (halted)
    );

    lc3_alu_sequencer #(
        .PC_RESET    (16'hFFFF),
        .HALT_VECTOR (8'h25)
    ) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n_w),
        .mem_req    (w_mem_req),
        .mem_addr   (w_mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_ctrl   (w_alu_ctrl),
        .alu_ir     (w_alu_ir),
        .sr1        (w_sr1),
        .sr2        (w_sr2),
        .dr         (w_dr),
        .reg_we     (w_reg_we),
        .alu_result (alu_result),
        .pc         (w_pc),
        .nzp        (w_nzp),
        .halted     (w_halted)
    );

    // Called on a negedge; waits (bounded) for mem_req, presents one word for one
    // edge and returns on the next negedge with the DUT in DECODE.
    task automatic drive_fetch(input logic [15:0] instr);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait mem_req=%b expected 1 (instr %h)", mem_req, instr);
        end
        mem_rdata = instr;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 16'h3000) begin errors++; $display("FAIL reset_pc got %h expected 3000", pc); end
        checks++;
        if (nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b expected 010", nzp); end
        checks++;
        if ({halted, mem_req, reg_we} !== 3'b000) begin
            errors++; $display("FAIL reset_flags halted/req/we got %b expected 000",
                               {halted, mem_req, reg_we});
        end
        checks++;
        if ({alu_ctrl, alu_ir, sr1, sr2, dr} !== 17'h0) begin
            errors++; $display("FAIL reset_ctrl got %h expected 0", {alu_ctrl, alu_ir, sr1, sr2, dr});
        end
        checks++;
        if (mem_addr !== 16'h3000) begin errors++; $display("FAIL reset_addr got %h expected 3000", mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin
            errors++; $display("FAIL first_req req=%b addr=%h expected 1/3000", mem_req, mem_addr);
        end
    endtask

    task automatic test_add();
        alu_result = 16'hFFFF;
        drive_fetch(16'h12BF);   // ADD R1,R2,#-1
        checks++;
        if (pc !== 16'h3001 || mem_req !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL add_decode pc=%h req=%b we=%b expected 3001/0/0", pc, mem_req, reg_we);
        end
        @(negedge clk);
        checks++;
        if (alu_ctrl !== 2'd1 || alu_ir !== 6'h3F) begin
            errors++; $display("FAIL add_alu ctrl=%0d ir=%h expected 1/3f", alu_ctrl, alu_ir);
        end
        checks++;
        if (sr1 !== 3'd2 || sr2 !== 3'd7 || dr !== 3'd1) begin
            errors++; $display("FAIL add_regs sr1=%0d sr2=%0d dr=%0d expected 2/7/1", sr1, sr2, dr);
        end
        checks++;
        if (reg_we !== 1'b1) begin errors++; $display("FAIL add_we_high got %b expected 1", reg_we); end
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0) begin errors++; $display("FAIL add_we_pulse got %b expected 0", reg_we); end
        checks++;
        if (nzp !== 3'b100) begin errors++; $display("FAIL add_nzp got %b expected 100", nzp); end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h3001) begin
            errors++; $display("FAIL add_next req=%b addr=%h expected 1/3001", mem_req, mem_addr);
        end
    endtask

    task automatic test_stall();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h3001 || pc !== 16'h3001 || reg_we !== 1'b0) begin
                errors++; $display("FAIL stall_%0d req=%b addr=%h pc=%h we=%b expected 1/3001/3001/0",
                                   i, mem_req, mem_addr, pc, reg_we);
            end
        end
        alu_result = 16'h0000;
        drive_fetch(16'h56E0);   // AND R3,R3,#0
        checks++;
        if (mem_req !== 1'b0 || pc !== 16'h3002) begin
            errors++; $display("FAIL stall_accept req=%b pc=%h expected 0/3002", mem_req, pc);
        end
        @(negedge clk);
        checks++;
        if (alu_ctrl !== 2'd2 || reg_we !== 1'b1 || sr1 !== 3'd3 || dr !== 3'd3 || alu_ir !== 6'h20) begin
            errors++; $display("FAIL and_exec ctrl=%0d we=%b sr1=%0d dr=%0d ir=%h expected 2/1/3/3/20",
                               alu_ctrl, reg_we, sr1, dr, alu_ir);
        end
        @(negedge clk);
        checks++;
        if (nzp !== 3'b010 || mem_addr !== 16'h3002) begin
            errors++; $display("FAIL and_zero nzp=%b addr=%h expected 010/3002", nzp, mem_addr);
        end
    endtask

    task automatic test_branch();
        alu_result = 16'h1234;
        for (int i = 0; i < 3; i++) drive_fetch(16'hD000);
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h3005 || nzp !== 3'b010 || alu_ctrl !== 2'd2 || reg_we !== 1'b0) begin
            errors++; $display("FAIL nop_run addr=%h nzp=%b ctrl=%0d we=%b expected 3005/010/2/0",
                               mem_addr, nzp, alu_ctrl, reg_we);
        end
        drive_fetch(16'h05FE);   // BRz #-2
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h3004 || pc !== 16'h3004) begin
            errors++; $display("FAIL brz_taken addr=%h pc=%h expected 3004/3004", mem_addr, pc);
        end
        drive_fetch(16'h0802);   // BRn #2, not taken
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h3005) begin errors++; $display("FAIL brn_not_taken addr=%h expected 3005", mem_addr); end
        drive_fetch(16'h0005);   // nzp field 000
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h3006) begin errors++; $display("FAIL br_none addr=%h expected 3006", mem_addr); end
        drive_fetch(16'h0E10);   // BRnzp #16
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h3017 || nzp !== 3'b010) begin
            errors++; $display("FAIL brnzp addr=%h nzp=%b expected 3017/010", mem_addr, nzp);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        rst_n_w = 1'b1;
        @(negedge clk);
        checks++;
        if (w_mem_req !== 1'b1 || w_mem_addr !== 16'hFFFF || w_pc !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_req req=%b addr=%h pc=%h expected 1/ffff/ffff",
                               w_mem_req, w_mem_addr, w_pc);
        end
        mem_rdata = 16'hD000;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if (w_pc !== 16'h0000 || w_reg_we !== 1'b0 || w_mem_req !== 1'b0) begin
            errors++; $display("FAIL wrap_pc pc=%h we=%b req=%b expected 0000/0/0", w_pc, w_reg_we, w_mem_req);
        end
        @(negedge clk);
        checks++;
        if (w_mem_req !== 1'b1 || w_mem_addr !== 16'h0000 || w_nzp !== 3'b010 || w_reg_we !== 1'b0
            || w_halted !== 1'b0 || w_alu_ctrl !== 2'd0) begin
            errors++; $display("FAIL wrap_next req=%b addr=%h nzp=%b we=%b expected 1/0000/010/0",
                               w_mem_req, w_mem_addr, w_nzp, w_reg_we);
        end
        rst_n_w = 1'b0;
    endtask

    task automatic test_trap();
        rst_n = 1'b1;
        @(negedge clk);
        drive_fetch(16'hF021);   // TRAP x21 behaves as NOP
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h3001) begin
            errors++; $display("FAIL trap21 halted=%b req=%b addr=%h expected 0/1/3001", halted, mem_req, mem_addr);
        end
        drive_fetch(16'hF025);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL halt_entry halted=%b req=%b expected 1/0", halted, mem_req);
        end
        mem_rdata = 16'h12BF;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0 || reg_we !== 1'b0 || pc !== 16'h3002) begin
                errors++; $display("FAIL halt_hold_%0d halted=%b req=%b we=%b pc=%h expected 1/0/0/3002",
                                   i, halted, mem_req, reg_we, pc);
            end
        end
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || pc !== 16'h3000) begin
            errors++; $display("FAIL halt_reset halted=%b pc=%h expected 0/3000", halted, pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_fetch(16'hD000);
        @(negedge clk);
        // Now stalled in FETCH at 3001; reset must abandon it asynchronously.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 16'h3000 || mem_addr !== 16'h3000) begin
            errors++; $display("FAIL async_reset req=%b pc=%h addr=%h expected 0/3000/3000", mem_req, pc, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin
            errors++; $display("FAIL restart req=%b addr=%h expected 1/3000", mem_req, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_branch();
        test_wrap();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
